// File: rtl/acc_pkg.sv
// Shared types and constants for the command-driven accumulator (adder_acc_ctrl).
package acc_pkg;

    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_t;

    typedef struct packed {
        op_t               op;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/acc_adder16.sv
// 16-bit two's complement adder/subtractor: SUB computes a - b as a + ~b + 1.
module acc_adder16
    import acc_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o,
    output logic              ovf_o
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   full_sum;

    assign b_eff    = b_i ^ {DATA_W{sub_i}};
    assign full_sum = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_i};
    assign sum_o    = full_sum[DATA_W-1:0];
    assign cout_o   = full_sum[DATA_W];
    // Signed overflow: operands of equal sign produce a result of the other sign.
    assign ovf_o    = (a_i[DATA_W-1] == b_eff[DATA_W-1]) &&
                      (sum_o[DATA_W-1] != a_i[DATA_W-1]);

endmodule

// File: rtl/acc_cmd_fifo.sv
// Count-based command FIFO, DEPTH x cmd_t; DEPTH must be a power of two so pointers wrap.
module acc_cmd_fifo
    import acc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  cmd_t wdata_i,
    input  logic pop_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    // NOTE: the storage array is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == DEPTH[PTR_W:0]);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/adder_acc_ctrl.sv
// Command FIFO -> single-issue FSM -> 16-bit adder -> registered result with valid/ready.
// Optional build macro ACC_SAT_EN: clamp ADD/SUB results on signed overflow.
module adder_acc_ctrl
    import acc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_ovf,
    output logic              res_cout,
    output logic [DATA_W-1:0] acc,
    output logic              sticky_ovf
);

    state_t            state_q, state_d;
    cmd_t              cmd_q;
    cmd_t              fifo_wdata, fifo_rdata;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d, cout_q, cout_d, sticky_q;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout, add_ovf;

    assign fifo_wdata.op   = op_t'(in_op);
    assign fifo_wdata.data = in_data;
    assign fifo_push       = in_valid && in_ready;

    acc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    acc_adder16 u_adder (
        .a_i    (acc_q),
        .b_i    (cmd_q.data),
        .sub_i  (cmd_q.op == OP_SUB),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .ovf_o  (add_ovf)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                fifo_pop = 1'b1;
                state_d  = EXEC;
            end
            EXEC: state_d = HOLD;
            HOLD: if (res_ready) begin
                fifo_pop = !fifo_empty;
                state_d  = fifo_empty ? IDLE : EXEC;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d  = '0;
        ovf_d  = 1'b0;
        cout_d = 1'b0;
        case (cmd_q.op)
            OP_LOAD: acc_d = cmd_q.data;
            OP_ADD, OP_SUB: begin
                acc_d  = add_sum;
                ovf_d  = add_ovf;
                cout_d = add_cout;
`ifdef ACC_SAT_EN
                // On overflow the true result has the sign of the old accumulator.
                if (add_ovf) acc_d = acc_q[DATA_W-1] ? SAT_NEG : SAT_POS;
`endif
            end
            default: acc_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= '{op: OP_LOAD, data: '0};
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) cmd_q <= fifo_rdata;
            if (state_q == EXEC) begin
                acc_q    <= acc_d;
                ovf_q    <= ovf_d;
                cout_q   <= cout_d;
                sticky_q <= (cmd_q.op == OP_LOAD || cmd_q.op == OP_CLR) ? 1'b0 : (sticky_q | ovf_d);
            end
        end
    end

    // The result register and the accumulator always hold the same value.
    assign in_ready   = !fifo_full;
    assign res_valid  = (state_q == HOLD);
    assign res_data   = acc_q;
    assign acc        = acc_q;
    assign res_ovf    = ovf_q;
    assign res_cout   = cout_q;
    assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_adder_acc_ctrl.sv
// Scoreboard bench for adder_acc_ctrl: directed commands push expected results, a monitor checks them.
module tb_adder_acc_ctrl;

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
        logic        cout;
        logic        sticky;
    } exp_t;

`ifdef ACC_SAT_EN
    localparam logic [15:0] EXP_ADD_OVF = 16'h7FFF;
    localparam logic [15:0] EXP_SUB_OVF = 16'h8000;
`else
    localparam logic [15:0] EXP_ADD_OVF = 16'h8000;
    localparam logic [15:0] EXP_SUB_OVF = 16'h7FFF;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [15:0] in_data = 16'h0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_ovf;
    logic        res_cout;
    logic [15:0] acc;
    logic        sticky_ovf;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   cyc = 0;
    int   last_hs = -1;
    bit   spacing_en = 1'b0;

    adder_acc_ctrl #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .res_cout   (res_cout),
        .acc        (acc),
        .sticky_ovf (sticky_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called in the drive phase (#1 after a rising edge); returns in the same phase.
    task automatic push(input logic [1:0] op, input logic [15:0] d, input bit track,
                        input logic [15:0] ed, input logic eo, input logic ec, input logic es);
        int t = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("push_in_ready_timeout", {31'b0, in_ready}, 32'd1);
        else if (track) sb.push_back('{data: ed, ovf: eo, cout: ec, sticky: es});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_scoreboard_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: got res_data %h, expected no result", res_data);
                end else begin
                    e = sb.pop_front();
                    check("res_data", {16'b0, res_data}, {16'b0, e.data});
                    check("res_ovf", {31'b0, res_ovf}, {31'b0, e.ovf});
                    check("res_cout", {31'b0, res_cout}, {31'b0, e.cout});
                    check("sticky_ovf", {31'b0, sticky_ovf}, {31'b0, e.sticky});
                    check("acc_matches_result", {16'b0, acc}, {16'b0, e.data});
                end
                if (spacing_en && last_hs >= 0) check("result_spacing", cyc - last_hs, 32'd2);
                last_hs = cyc;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_res_data", {16'b0, res_data}, 32'd0);
        check("rst_res_ovf", {31'b0, res_ovf}, 32'd0);
        check("rst_res_cout", {31'b0, res_cout}, 32'd0);
        check("rst_acc", {16'b0, acc}, 32'd0);
        check("rst_sticky", {31'b0, sticky_ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LOAD / SUB with borrow
        res_ready = 1'b1;
        push(2'b00, 16'h0005, 1, 16'h0005, 0, 0, 0);
        push(2'b10, 16'h0007, 1, 16'hFFFE, 0, 0, 0);
        drain();

        // Positive overflow on ADD, sticky holds through a clean ADD
        push(2'b00, 16'h7FFF, 1, 16'h7FFF, 0, 0, 0);
        push(2'b01, 16'h0001, 1, EXP_ADD_OVF, 1, 0, 1);
        push(2'b01, 16'h0000, 1, EXP_ADD_OVF, 0, 0, 1);
        drain();

        // Negative overflow on SUB, then CLR clears sticky
        push(2'b00, 16'h8000, 1, 16'h8000, 0, 0, 0);
        push(2'b10, 16'h0001, 1, EXP_SUB_OVF, 1, 1, 1);
        push(2'b11, 16'hABCD, 1, 16'h0000, 0, 0, 0);
        drain();

        // Fill: DEPTH+1 accepted while the consumer stalls
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(2'b01, 16'h0001, 1, 16'(i), 0, 0, 0);
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_data  = 16'h0001;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready_low", {31'b0, in_ready}, 32'd0);
        end
        check("hold_acc_first", {16'b0, acc}, 32'h0001);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        spacing_en = 1'b1;
        last_hs    = -1;
        res_ready  = 1'b1;
        drain();
        spacing_en = 1'b0;

        // Push and pop in the same cycle at count = DEPTH-1
        res_ready = 1'b0;
        push(2'b00, 16'h0100, 1, 16'h0100, 0, 0, 0);
        push(2'b01, 16'h0001, 1, 16'h0101, 0, 0, 0);
        push(2'b01, 16'h0001, 1, 16'h0102, 0, 0, 0);
        push(2'b01, 16'h0001, 1, 16'h0103, 0, 0, 0);
        spacing_en = 1'b1;
        last_hs    = -1;
        res_ready  = 1'b1;
        push(2'b01, 16'h0010, 1, 16'h0113, 0, 0, 0);
        @(negedge clk);
        check("b2b_in_ready_stays", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        push(2'b01, 16'h0010, 1, 16'h0123, 0, 0, 0);
        drain();
        spacing_en = 1'b0;

        // Asynchronous reset while holding a result with 3 commands queued
        res_ready = 1'b0;
        push(2'b00, 16'h0055, 0, 16'h0, 0, 0, 0);
        push(2'b01, 16'h0001, 0, 16'h0, 0, 0, 0);
        push(2'b01, 16'h0001, 0, 16'h0, 0, 0, 0);
        push(2'b01, 16'h0001, 0, 16'h0, 0, 0, 0);
        @(negedge clk);
        check("pre_rst_res_valid", {31'b0, res_valid}, 32'd1);
        check("pre_rst_acc", {16'b0, acc}, 32'h0055);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("mid_rst_acc", {16'b0, acc}, 32'd0);
        check("mid_rst_res_data", {16'b0, res_data}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_stale", {31'b0, res_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        push(2'b00, 16'h1234, 1, 16'h1234, 0, 0, 0);
        drain();
        repeat (4) @(negedge clk);
        check("final_scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_acc_ctrl.md
# adder_acc_ctrl

Command-driven 16-bit accumulator that sits directly upstream of the 16-bit adder/subtractor and feeds it. It buffers LOAD/ADD/SUB/CLR commands in a small FIFO, issues one command at a time to the adder with the accumulator as operand A, and registers SUM/overflow/carry. Results are presented on a valid/ready output port, with a sticky overflow flag for software status.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  command valid
- in_ready  out  1  FIFO not full; command accepted on in_valid && in_ready
- in_op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR
- in_data  in  16  operand (ignored for CLR)
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result on res_valid && res_ready
- res_data  out  16  new accumulator value
- res_ovf  out  1  signed overflow of this operation
- res_cout  out  1  adder carry-out (SUB: 1 = no borrow)
- acc  out  16  current accumulator
- sticky_ovf  out  1  OR of res_ovf since last LOAD/CLR

## Operation
- Reset values: in_ready=1, res_valid=0, res_data=0, res_ovf=0, res_cout=0, acc=0, sticky_ovf=0, FIFO empty, FSM IDLE.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: FIFO non-empty → pop, go EXEC; else stay.
  - EXEC: adder driven A=acc, B=data, Add_ctrl=(op==SUB). At the edge: acc and res_* loaded, res_valid←1, go HOLD.
  - HOLD: res_valid=1, outputs stable. On res_ready: res_valid←0; if FIFO non-empty, pop and go EXEC, else go IDLE.
- Op results:
  - LOAD: acc←data, ovf=0, cout=0.
  - ADD: acc←acc+data.
  - SUB: acc←acc−data; ovf and cout taken from adder.
  - CLR: acc←0, ovf=0, cout=0.
- sticky_ovf is cleared by LOAD/CLR, set by any ADD/SUB with ovf=1, and otherwise holds.
- All arithmetic is 16-bit two's complement. Carry beyond bit 15 is visible only on res_cout.
- FIFO: in_ready = !full. A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH. A push while full is impossible by handshake. A pop while empty never occurs.
- Reset mid-operation drops the in-flight command, empties the FIFO, and forces all outputs to their reset values immediately (asynchronously).

## Timing
- Latency: a command accepted at edge E0 into an empty FIFO with FSM IDLE is popped at E1 and gives res_valid=1 after E2.
- Throughput: one result per 2 cycles with res_ready held high (HOLD→EXEC at the handshake edge).
- The command in EXEC/HOLD is not counted in the FIFO, so with res_ready=0 the block accepts DEPTH+1 commands before in_ready drops.
- res_* and acc are registered outputs; no combinational path from in_* to res_*.
- in_ready depends only on FIFO count, not on in_valid.

## Configuration
- ACC_SAT_EN defined: on ADD/SUB with ovf=1, res_data/acc clamp to 0x7FFF if the true result is positive (acc[15]==0), else 0x8000. res_ovf and sticky_ovf are still set, and res_cout is passed from the adder unchanged.
- ACC_SAT_EN undefined: wrapped adder SUM is used unchanged.

## Structure
- Shared package acc_pkg holds the op_t enum (OP_LOAD, OP_ADD, OP_SUB, OP_CLR), the state_t enum (IDLE, EXEC, HOLD), the DATA_W=16 constant, and the SAT_POS/SAT_NEG constants.
- The sub-module acc_cmd_fifo (DEPTH × 18-bit, count-based full/empty) holds the commands.
- The existing 16-bit adder is instantiated as the datapath. Top level contains FSM, accumulator, and result registers.

## Test plan
- LOAD 0x0005, SUB 0x0007, res_ready=1 → results 0x0005; then 0xFFFE with ovf=0, cout=0; sticky_ovf=0.
- LOAD 0x7FFF, ADD 0x0001 → 0x8000, ovf=1, cout=0, sticky_ovf=1 (with ACC_SAT_EN: 0x7FFF, ovf=1).
- LOAD 0x8000, SUB 0x0001 → 0x7FFF, ovf=1 (ACC_SAT_EN: 0x8000). Then CLR → 0x0000, sticky_ovf=0.
- res_ready=0, push 6 × ADD 0x0001 → 5 accepted, in_ready=0 on 6th. Release res_ready → results 0x0001…0x0005 in order, each res_valid for ≥1 cycle, 2-cycle spacing.
- Back-to-back with push and pop in the same cycle at count=DEPTH−1 → count stable, in_ready stays 1, no command lost or duplicated.
- Assert rst_n low while in HOLD with 3 queued → res_valid=0, acc=0, in_ready=1 immediately. After release, a new LOAD 0x1234 gives 0x1234 with no stale results.
